// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, default widths and helpers for the pong match controller
package pong_pkg;

    // Encoding of the game_state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam int DEFAULT_SCORE_W = 4;

    // Index width for n items; never narrower than one bit so a
    // single-bit select still exists for the smallest configurations.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pong_debounce.sv
// rtl/pong_debounce.sv - millisecond-sampled button debouncer with press pulse
//
// Ports:
//   clk      system clock
//   reset    synchronous active-low reset (debounced level -> released)
//   clk_1ms  one-clk tick per millisecond, the only time raw is sampled
//   raw      raw active-high button level, already in the clk domain
//   press    one-clk pulse on a rising edge of the debounced level
module pong_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_1ms,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // r_cnt counts consecutive ticks at which raw disagreed with the accepted
    // level; any agreeing tick restarts the run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (clk_1ms) begin
                if (raw == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
                    r_level <= raw;
                    r_cnt   <= '0;
                    r_press <= raw;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - N-player pong match flow: serve countdown, rally, pause, game over
//
// Ports:
//   clk, reset       system clock, synchronous active-low reset
//   clk_1ms          one-clk millisecond tick
//   start_btn        raw start button
//   pause_btn        raw pause button
//   point_pulse      bit i pulses when player i scores
//   scores           packed per-player scores, player 0 in the LSBs
//   game_state       00 IDLE, 01 SERVE, 10 PLAY, 11 OVER
//   paused           match frozen
//   serve_side       player receiving the next serve
//   winner           winning player, meaningful in OVER
//   ball_release     one-clk pulse when the serve countdown expires
//   serve_count      remaining serve countdown ticks
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = DEFAULT_SCORE_W,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_MS    = 1000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clk_1ms,
    input  logic                                  start_btn,
    input  logic                                  pause_btn,
    input  logic [NUM_PLAYERS-1:0]                point_pulse,
    output logic [NUM_PLAYERS*SCORE_W-1:0]        scores,
    output logic [1:0]                            game_state,
    output logic                                  paused,
    output logic [clog2_min1(NUM_PLAYERS)-1:0]    serve_side,
    output logic [clog2_min1(NUM_PLAYERS)-1:0]    winner,
    output logic                                  ball_release,
    output logic [$clog2(SERVE_MS+1)-1:0]         serve_count
);

    localparam int PW = clog2_min1(NUM_PLAYERS);
    localparam int TW = $clog2(SERVE_MS + 1);

    state_t             r_state;
    logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
    logic               r_paused;
    logic [PW-1:0]      r_side;
    logic [PW-1:0]      r_winner;
    logic               r_release;
    logic [TW-1:0]      r_count;

    logic               w_start_p;
    logic               w_pause_p;
    logic               w_pt_any;
    logic [PW-1:0]      w_pt_idx;
    logic [PW-1:0]      w_next_side;
    logic [SCORE_W-1:0] w_pt_score;

    pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
        .clk     (clk),
        .reset   (reset),
        .clk_1ms (clk_1ms),
        .raw     (start_btn),
        .press   (w_start_p)
    );

    pong_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
        .clk     (clk),
        .reset   (reset),
        .clk_1ms (clk_1ms),
        .raw     (pause_btn),
        .press   (w_pause_p)
    );

    // Lowest-index scorer wins; scanning downward lets the lowest set bit
    // overwrite any higher one.
    always_comb begin
        w_pt_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (point_pulse[i]) w_pt_idx = PW'(i);
        end
    end

    assign w_pt_any    = |point_pulse;
    assign w_pt_score  = r_score[w_pt_idx] + 1'b1;
    assign w_next_side = (w_pt_idx == PW'(NUM_PLAYERS - 1)) ? '0 : w_pt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
            r_paused  <= 1'b0;
            r_side    <= '0;
            r_winner  <= '0;
            r_release <= 1'b0;
            r_count   <= '0;
        end else begin
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_p) begin
                        r_state <= ST_SERVE;
                        for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
                        r_side  <= '0;
                        r_count <= TW'(SERVE_MS);
                    end
                end
                ST_SERVE: begin
                    if (w_pause_p) begin
                        r_paused <= ~r_paused;
                    end else if (!r_paused && clk_1ms) begin
                        if (r_count == TW'(1)) begin
                            r_count   <= '0;
                            r_state   <= ST_PLAY;
                            r_release <= 1'b1;
                        end else begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // A point landing with a pause press is dropped.
                    if (w_pause_p) begin
                        r_paused <= ~r_paused;
                    end else if (!r_paused && w_pt_any) begin
                        r_score[w_pt_idx] <= w_pt_score;
                        r_paused          <= 1'b0;
                        if (w_pt_score == SCORE_W'(WIN_SCORE)) begin
                            r_state  <= ST_OVER;
                            r_winner <= w_pt_idx;
                        end else begin
                            r_state <= ST_SERVE;
                            r_side  <= w_next_side;
                            r_count <= TW'(SERVE_MS);
                        end
                    end
                end
                ST_OVER: begin
                    if (w_start_p) begin
                        r_state <= ST_SERVE;
                        for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
                        r_side  <= r_winner;
                        r_count <= TW'(SERVE_MS);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
    end

    assign game_state   = r_state;
    assign paused       = r_paused;
    assign serve_side   = r_side;
    assign winner       = r_winner;
    assign ball_release = r_release;
    assign serve_count  = r_count;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - self-checking bench for pong_match_ctrl against a behavioural model
module tb_pong_match_ctrl;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int WIN = 3;
    localparam int SMS = 3;
    localparam int DB  = 2;

    logic          clk;
    logic          reset;
    logic          clk_1ms;
    logic          start_btn;
    logic          pause_btn;
    logic [N-1:0]  point_pulse;
    logic [N*W-1:0] scores;
    logic [1:0]    game_state;
    logic          paused;
    logic [1:0]    serve_side;
    logic [1:0]    winner;
    logic          ball_release;
    logic [1:0]    serve_count;

    pong_match_ctrl #(
        .NUM_PLAYERS (N),
        .SCORE_W     (W),
        .WIN_SCORE   (WIN),
        .SERVE_MS    (SMS),
        .DEBOUNCE_MS (DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_1ms      (clk_1ms),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .point_pulse  (point_pulse),
        .scores       (scores),
        .game_state   (game_state),
        .paused       (paused),
        .serve_side   (serve_side),
        .winner       (winner),
        .ball_release (ball_release),
        .serve_count  (serve_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic sb = 1'b0;
    logic pb = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: match state as plain integers, debounce as a
    // history of the last DB millisecond samples.
    int m_state, m_side, m_winner, m_cnt;
    int m_score [N];
    bit m_paused, m_rel, m_sp, m_pp, m_slvl, m_plvl;
    bit m_sh [DB];
    bit m_ph [DB];

    always @(posedge clk) begin
        int  lo;
        bit  all_s, all_p, nsp, npp;
        if (!reset) begin
            m_state = 0; m_side = 0; m_winner = 0; m_cnt = 0;
            for (int k = 0; k < N; k++) m_score[k] = 0;
            m_paused = 0; m_rel = 0; m_sp = 0; m_pp = 0; m_slvl = 0; m_plvl = 0;
            for (int k = 0; k < DB; k++) begin m_sh[k] = 0; m_ph[k] = 0; end
        end else begin
            m_rel = 0;
            case (m_state)
                0: if (m_sp) begin
                    m_state = 1; m_side = 0; m_cnt = SMS;
                    for (int k = 0; k < N; k++) m_score[k] = 0;
                end
                1: if (m_pp) m_paused = !m_paused;
                   else if (!m_paused && clk_1ms) begin
                       if (m_cnt == 1) begin m_cnt = 0; m_state = 2; m_rel = 1; end
                       else m_cnt = m_cnt - 1;
                   end
                2: if (m_pp) m_paused = !m_paused;
                   else if (!m_paused && point_pulse != 0) begin
                       lo = -1;
                       for (int k = 0; k < N; k++) if (lo < 0 && point_pulse[k]) lo = k;
                       m_score[lo] = m_score[lo] + 1;
                       if (m_score[lo] == WIN) begin
                           m_state = 3; m_winner = lo;
                       end else begin
                           m_state = 1; m_side = (lo + 1) % N; m_cnt = SMS;
                       end
                   end
                default: if (m_sp) begin
                    m_state = 1; m_side = m_winner; m_cnt = SMS;
                    for (int k = 0; k < N; k++) m_score[k] = 0;
                end
            endcase
            nsp = 0; npp = 0;
            if (clk_1ms) begin
                for (int k = DB - 1; k > 0; k--) begin m_sh[k] = m_sh[k-1]; m_ph[k] = m_ph[k-1]; end
                m_sh[0] = start_btn; m_ph[0] = pause_btn;
                all_s = 1; all_p = 1;
                for (int k = 0; k < DB; k++) begin
                    if (m_sh[k] == m_slvl) all_s = 0;
                    if (m_ph[k] == m_plvl) all_p = 0;
                end
                if (all_s) begin m_slvl = !m_slvl; nsp = m_slvl; end
                if (all_p) begin m_plvl = !m_plvl; npp = m_plvl; end
            end
            m_sp = nsp; m_pp = npp;
        end
    end

    function automatic logic [N*W-1:0] m_packed();
        logic [N*W-1:0] v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(m_score[k]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", game_state, m_state);
            chk("scores", scores, m_packed());
            chk("paused", paused, m_paused);
            chk("serve_side", serve_side, m_side);
            chk("ball_release", ball_release, m_rel);
            chk("serve_count", serve_count, m_cnt);
            if (m_state == 3) chk("winner", winner, m_winner);
        end
    end

    task automatic cyc(input logic t, input logic [N-1:0] pts);
        clk_1ms = t; start_btn = sb; pause_btn = pb; point_pulse = pts;
        @(posedge clk); #1;
        clk_1ms = 1'b0; point_pulse = '0;
    endtask

    task automatic ms(input int n);
        repeat (n) begin cyc(1, '0); cyc(0, '0); cyc(0, '0); cyc(0, '0); end
    endtask

    initial begin
        logic [N-1:0] pts;
        logic         t;
        reset = 1'b0; clk_1ms = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; point_pulse = '0;
        cyc(0, '0); cyc(0, '0);
        chk("lit_reset_state", game_state, 2'b00);
        chk("lit_reset_scores", scores, 16'h0000);
        chk("lit_reset_count", serve_count, 2'd0);
        reset = 1'b1;
        chk_en = 1'b1;

        // start: accepted on the second tick, state moves one clk later
        sb = 1'b1;
        cyc(1, '0); cyc(0, '0); cyc(1, '0);
        chk("lit_start_latency", game_state, 2'b00);
        cyc(0, '0);
        chk("lit_serve_state", game_state, 2'b01);
        chk("lit_serve_count", serve_count, 2'd3);
        sb = 1'b0;
        cyc(1, '0); cyc(0, '0); cyc(1, '0); cyc(0, '0);
        chk("lit_count_1", serve_count, 2'd1);
        cyc(1, '0);
        chk("lit_play_state", game_state, 2'b10);
        chk("lit_release_hi", ball_release, 1'b1);
        cyc(0, '0);
        chk("lit_release_lo", ball_release, 1'b0);

        // simultaneous points: lowest index wins
        cyc(0, 4'b0011);
        chk("lit_arb_scores", scores, 16'h0001);
        chk("lit_arb_side", serve_side, 2'd1);
        chk("lit_arb_state", game_state, 2'b01);
        ms(3);
        cyc(0, 4'b1000);
        chk("lit_p3_scores", scores, 16'h1001);
        chk("lit_p3_side", serve_side, 2'd0);
        ms(3);

        // pause lands in SERVE at count 2
        pb = 1'b1;
        cyc(1, '0); cyc(0, 4'b0010); cyc(0, '0); cyc(1, '0); cyc(0, '0);
        chk("lit_paused", paused, 1'b1);
        chk("lit_paused_count", serve_count, 2'd2);
        pb = 1'b0;
        ms(10);
        chk("lit_frozen_count", serve_count, 2'd2);
        pb = 1'b1;
        ms(2);
        chk("lit_unpaused", paused, 1'b0);
        pb = 1'b0;
        ms(2);
        chk("lit_resume_play", game_state, 2'b10);

        // player 1 reaches WIN_SCORE
        cyc(0, 4'b0010);
        ms(3);
        cyc(0, 4'b0010);
        chk("lit_over_state", game_state, 2'b11);
        chk("lit_over_winner", winner, 2'd1);
        chk("lit_over_scores", scores, 16'h1031);
        cyc(0, 4'b1111);
        chk("lit_over_hold", scores, 16'h1031);

        // one-tick glitch is not a press
        sb = 1'b1; cyc(1, '0); sb = 1'b0;
        ms(3);
        chk("lit_glitch", game_state, 2'b11);

        // restart serves to the winner
        sb = 1'b1; ms(2);
        chk("lit_restart_state", game_state, 2'b01);
        chk("lit_restart_side", serve_side, 2'd1);
        chk("lit_restart_scores", scores, 16'h0000);
        sb = 1'b0; ms(3);
        cyc(0, 4'b0001);
        ms(3);
        chk("lit_mid_play", game_state, 2'b10);
        reset = 1'b0;
        cyc(0, '0);
        chk("lit_rst_state", game_state, 2'b00);
        chk("lit_rst_scores", scores, 16'h0000);
        chk("lit_rst_paused", paused, 1'b0);
        chk("lit_rst_release", ball_release, 1'b0);
        reset = 1'b1;

        // randomized phase checked by the model
        for (int c = 0; c < 6000; c++) begin
            reset = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 29) == 0) sb = ~sb;
            if ($urandom_range(0, 24) == 0) pb = ~pb;
            t   = ($urandom_range(0, 3) == 0);
            pts = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cyc(t, pts);
        end
        reset = 1'b1;
        cyc(0, '0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Parametrised successor to the fixed two-player score/game-state logic.
- Owns the match flow: start, timed serve countdown, rally, pause, and game-over with winner. Serves N players with configurable win score.
- Sits between the ball/collision logic, which supplies point pulses, and the render/seven-segment blocks, which consume scores and state.
- Includes debouncing of the start and pause buttons.

Parameters:
- NUM_PLAYERS, 2, number of players/score channels (2..8).
- SCORE_W, 4, bits per score.
- WIN_SCORE, 9, score that ends the match. Constraint: 1 <= WIN_SCORE <= 2^SCORE_W-1.
- SERVE_MS, 1000, serve countdown length in clk_1ms ticks. Must be >= 1.
- DEBOUNCE_MS, 20, consecutive stable ticks required to accept a button level.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- clk_1ms  in  1  one-clk-wide tick, once per ms, in the clk domain.
- start_btn  in  1  raw start button, active-high.
- pause_btn  in  1  raw pause button, active-high.
- point_pulse  in  NUM_PLAYERS  bit i pulses for one clk when player i scores.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in the LSBs.
- game_state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER.
- paused  out  1  match is frozen.
- serve_side  out  PW = max(1,$clog2(NUM_PLAYERS))  player receiving the next serve.
- winner  out  PW  valid only in OVER.
- ball_release  out  1  one-clk pulse on the SERVE->PLAY transition.
- serve_count  out  TW = $clog2(SERVE_MS+1)  remaining countdown ticks.

Behaviour:
- Reset (reset==0 at a clk edge) forces:
  - game_state=IDLE; scores=0; paused=0; serve_side=0; winner=0; ball_release=0; serve_count=0.
  - Debouncers cleared to the released state.
- Debounce:
  - Each button is sampled only on clk_1ms.
  - The debounced level changes after DEBOUNCE_MS consecutive ticks at the new level.
  - A rising edge of the debounced level produces a one-clk press pulse (start_p, pause_p).
- IDLE:
  - start_p -> SERVE. serve_side=0, serve_count=SERVE_MS, scores=0.
  - point_pulse is ignored.
- SERVE:
  - On each clk_1ms while !paused, serve_count decrements.
  - On the tick where serve_count==1: serve_count becomes 0, state -> PLAY, and ball_release=1 in the following cycle only.
  - point_pulse is ignored.
- PLAY:
  - Any point_pulse bit set while !paused is arbitrated: lowest index i wins and other simultaneous bits are dropped.
  - score[i]+1 is registered the next cycle.
  - If score[i]+1 == WIN_SCORE: state -> OVER, winner=i.
  - Otherwise: state -> SERVE, serve_side=(i+1) mod NUM_PLAYERS, serve_count=SERVE_MS.
  - Scores never exceed WIN_SCORE; there is no wrap.
- Pause:
  - pause_p in SERVE or PLAY toggles paused.
  - While paused: serve_count is frozen, point_pulse is ignored, and the state is held.
  - pause_p in IDLE or OVER is ignored.
  - Leaving SERVE/PLAY for any reason clears paused.
- Same-cycle priority (highest first): reset > pause_p > point_pulse > clk_1ms countdown. A point arriving in the same cycle as pause_p is dropped.
- OVER:
  - Scores and winner are held.
  - start_p -> SERVE with scores=0, serve_side=winner, serve_count=SERVE_MS.
- start_p outside IDLE/OVER is ignored.
- Latency:
  - Button to state change: DEBOUNCE_MS ticks plus 2 clk.
  - point_pulse to score update: 1 clk.
- All outputs are registered.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding constants ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER;
  - default SCORE_W;
  - a helper function for clog2-with-minimum-1.
- One sub-module: pong_debounce (parameter DEBOUNCE_MS; ports clk, reset, clk_1ms, raw, press).
  - Instantiated twice.

Test Plan:
- Reset mid-PLAY with scores {3,5} -> next clk: game_state=00, scores=0, paused=0, ball_release=0.
- SERVE_MS=3, DEBOUNCE_MS=2: start held 2 ticks -> SERVE with serve_count=3. After 3 ticks -> PLAY, ball_release high exactly 1 clk.
- PLAY, point_pulse=2'b11 -> score0=1, score1=0, state SERVE, serve_side=1.
- WIN_SCORE=3, player1 scores 3 times -> game_state=11, winner=1, score1=3. A further point_pulse leaves scores unchanged.
- Pause in SERVE at serve_count=2 -> 10 ticks later serve_count still 2. Unpause, 2 ticks -> PLAY.
- NUM_PLAYERS=4: point_pulse=4'b1000 -> score3=1, serve_side=0. Button glitch shorter than DEBOUNCE_MS -> no press.
